mux4_rr_arbiter: RTL and testbench
==================================

// Module: mux4_rr_arbiter
// PURPOSE
//  Round-robin arbiter that shares one WIDTH-bit output channel among four requesters.
//  It drives the 2-bit select of a 4:1 data mux and carries a valid/ready handshake
//  on the output. A granted requester keeps the channel for a whole burst, ending at
//  its last beat. Sits between four producers and a single shared sink.
// PARAMETERS
//  WIDTH      8  data width of every requester input and of o_data
//  LOCK_BURST 1  1: grant held until beat with last=1; 0: grant released every beat
// PORTS
//  clk     in   1        single clock, all state on rising edge
//  rst     in   1        synchronous, active-high reset
//  req     in   4        req[i]: requester i has a beat valid on d<i>
//  last    in   4        last[i]: current beat of requester i ends its burst
//  d0..d3  in   WIDTH    requester data inputs
//  o_data  out  WIDTH    muxed data = d<sel>
//  o_valid out  1        beat valid toward sink
//  o_ready in   1        sink accepts beat when o_valid && o_ready
//  ack     out  4        one-hot; ack[i]=1 in the cycle requester i's beat transfers
//  sel     out  2        registered grant index; drives mux select (sel[1]=s1, sel[0]=s0)
//  busy    out  1        1 while in BUSY state
// BEHAVIOUR
//  - Reset (rst=1 at edge): state=IDLE, sel=0, ptr=0, busy=0. o_valid=0, ack=0.
//    o_data = d0 (combinational). Reset mid-burst aborts the burst; no ack is issued.
//  - ptr[1:0] = highest-priority index. Priority order is ptr, ptr+1, ptr+2, ptr+3 (mod 4).
//  - IDLE: o_valid=0, ack=0. If req!=0, sel<=first set req in priority order,
//    state<=BUSY. Otherwise stay. Latency from req to o_valid is exactly 1 cycle.
//  - BUSY: o_valid = req[sel]. o_data = d<sel>. busy=1.
//    ack[sel] = o_valid && o_ready (combinational). All other ack bits are 0.
//  - Transfer in BUSY with (last[sel] || LOCK_BURST==0): end of grant.
//    ptr<=sel+1 (wraps 3->0). state<=IDLE. One idle bubble always follows a grant.
//  - Transfer with last[sel]=0 and LOCK_BURST=1: stay BUSY with sel unchanged.
//  - req[sel] drops in BUSY without last: grant held, o_valid=0 (stall).
//    Other requesters are not served until requester sel completes its last beat.
//  - o_ready=0 while o_valid=1: hold everything. d<sel> and last[sel] must stay
//    stable; this is a requester obligation and is checked by assertion.
//  - Requests arriving while BUSY are only considered at the next IDLE.
//  - last[] and d<i> are ignored for any i != sel.
//  - No starvation: any held req is granted within 4 grants.
// STRUCTURE
//  - Shared package mux_arb_pkg: NUM_REQ=4, SEL_W=2, state encoding
//    (ST_IDLE=1'b0, ST_BUSY=1'b1), and the rr_pick function (req, ptr -> index).
//  - Sub-module mux4to1_bus #(WIDTH): WIDTH-bit 4:1 mux (d0..d3, s0, s1 -> o),
//    built as a tree of three 2:1 stages. It carries o_data.
//    The arbiter holds only the FSM, ptr, sel and handshake logic.
// TESTING
//  1 Reset: assert rst 2 cycles with req=4'hF -> o_valid=0, ack=0, sel=0, busy=0
//    throughout; first grant after release is sel=0.
//  2 Rotation: req=4'hF, last=4'hF, o_ready=1 held -> grants sel=0,1,2,3,0.
//    ack pulses every 2nd cycle; o_data=d<sel>.
//  3 Burst lock: req=4'b0011, requester 0 sends 3 beats (last on 3rd)
//    -> ack[0] 3 consecutive cycles, no ack[1].
//    Then after 1 bubble, sel=1 with o_data=d1.
//  4 Backpressure: sel=2 granted, o_ready=0 for 5 cycles -> o_valid=1, ack=0, sel=2 held.
//    o_ready=1 -> single ack[2]=1.
//  5 Wrap/fairness: ptr=3, req=4'b1001 -> sel=3 first, then sel=0. After that grant, ptr=1.
//  6 Reset mid-burst: rst during beat 2 of a 4-beat burst from requester 1
//    -> IDLE next cycle, ptr=0, no ack that cycle.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// ----------------------------------------------------------------------------
// mux_arb_pkg
//   Shared definitions for the four-requester round-robin mux arbiter:
//   requester count, select width, FSM state encoding and the rotating
//   priority pick used to choose the next grant.
// ----------------------------------------------------------------------------
package mux_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    // Returns the first set bit of req scanning ptr, ptr+1, ptr+2, ptr+3
    // (mod 4). With no request pending the result is ptr; callers only use
    // the result when req is non-zero.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                 input logic [SEL_W-1:0]   ptr);
        logic [SEL_W-1:0] idx;
        logic [SEL_W-1:0] pick;
        logic             found;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = ptr + SEL_W'(i);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/mux4to1_bus.sv
// ----------------------------------------------------------------------------
// mux4to1_bus
//   WIDTH-bit 4:1 data multiplexer built as a tree of three 2:1 stages:
//   s0 picks within each pair, s1 picks between the pairs.
// Ports
//   d0..d3  in   WIDTH  data inputs
//   s0      in   1      select bit 0
//   s1      in   1      select bit 1
//   o       out  WIDTH  selected data
// ----------------------------------------------------------------------------
module mux4to1_bus #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic             s0,
    input  logic             s1,
    output logic [WIDTH-1:0] o
);

    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;

    assign lo = s0 ? d1 : d0;
    assign hi = s0 ? d3 : d2;
    assign o  = s1 ? hi : lo;

endmodule

// File: rtl/mux4_rr_arbiter.sv
// ----------------------------------------------------------------------------
// mux4_rr_arbiter
//   Round-robin arbiter sharing one WIDTH-bit output channel among four
//   requesters. A grant is held for a whole burst (up to the beat flagged by
//   last) when LOCK_BURST=1, or for a single beat when LOCK_BURST=0. Every
//   grant is followed by one idle bubble, during which the next requester is
//   picked with rotating priority starting at ptr.
// Ports
//   clk      in   1      clock, all state on rising edge
//   rst      in   1      synchronous active-high reset
//   req      in   4      per-requester beat valid
//   last     in   4      per-requester end-of-burst flag
//   d0..d3   in   WIDTH  requester data
//   o_data   out  WIDTH  d<sel>
//   o_valid  out  1      beat valid toward sink
//   o_ready  in   1      sink ready
//   ack      out  4      one-hot transfer acknowledge to the granted requester
//   sel      out  2      registered grant index / mux select
//   busy     out  1      high while a grant is active
// ----------------------------------------------------------------------------
module mux4_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int LOCK_BURST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic [3:0]       last,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [3:0]       ack,
    output logic [1:0]       sel,
    output logic             busy
);

    arb_state_t       state;
    logic [SEL_W-1:0] ptr;
    logic             xfer;
    logic             grant_end;

    mux4to1_bus #(
        .WIDTH (WIDTH)
    ) u_mux (
        .d0 (d0),
        .d1 (d1),
        .d2 (d2),
        .d3 (d3),
        .s0 (sel[0]),
        .s1 (sel[1]),
        .o  (o_data)
    );

    assign busy = (state == ST_BUSY);

    // A reset asserted mid-burst suppresses the beat in that same cycle so
    // the requester never sees an ack for a beat the arbiter then forgets.
    assign o_valid   = busy && req[sel] && !rst;
    assign xfer      = o_valid && o_ready;
    assign grant_end = xfer && (last[sel] || (LOCK_BURST == 0));

    always_comb begin
        ack = 4'b0000;
        if (xfer) begin
            ack[sel] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            sel   <= '0;
            ptr   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req != 4'b0000) begin
                        sel   <= rr_pick(req, ptr);
                        state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // Mid-burst transfers and stalls keep sel; only the
                    // closing beat rotates priority past the current owner.
                    if (grant_end) begin
                        ptr   <= sel + SEL_W'(1);
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // A stalled beat must be presented unchanged until the sink takes it.
    a_hold_stable: assert property (
        @(posedge clk) disable iff (rst)
        (o_valid && !o_ready) |=> ((o_data == $past(o_data)) && (last[sel] == $past(last[sel])))
    );

    a_ack_onehot: assert property (
        @(posedge clk) disable iff (rst)
        $onehot0(ack)
    );

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mux4_rr_arbiter
//   Scripted cycle-by-cycle stimulus. Each cycle's expected outputs are
//   pushed into a scoreboard queue as the inputs are driven, and popped and
//   compared on the following falling edge.
// ----------------------------------------------------------------------------
module tb_mux4_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] last;
    logic [7:0] d0, d1, d2, d3;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_ready;
    logic [3:0] ack;
    logic [1:0] sel;
    logic       busy;

    typedef struct {
        logic       valid;
        logic [3:0] ack;
        logic [1:0] sel;
        logic       busy;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    int   errs = 0;
    int   nchk = 0;

    always #5 clk = ~clk;

    mux4_rr_arbiter #(
        .WIDTH      (8),
        .LOCK_BURST (1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .last    (last),
        .d0      (d0),
        .d1      (d1),
        .d2      (d2),
        .d3      (d3),
        .o_data  (o_data),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .ack     (ack),
        .sel     (sel),
        .busy    (busy)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("o_valid", 32'(o_valid), 32'(e.valid));
            chk("ack",     32'(ack),     32'(e.ack));
            chk("sel",     32'(sel),     32'(e.sel));
            chk("busy",    32'(busy),    32'(e.busy));
            chk("o_data",  32'(o_data),  32'(e.data));
        end
    end

    // Drive one cycle of inputs, queue the outputs expected for that cycle,
    // then advance to just after the next rising edge.
    task automatic cyc(input logic r, input logic [3:0] rq, input logic [3:0] ls,
                       input logic rd, input logic ev, input logic [3:0] ea,
                       input logic [1:0] es, input logic eb, input logic [7:0] ed);
        exp_t e;
        rst     = r;
        req     = rq;
        last    = ls;
        o_ready = rd;
        e.valid = ev;
        e.ack   = ea;
        e.sel   = es;
        e.busy  = eb;
        e.data  = ed;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; req = 4'h0; last = 4'h0; o_ready = 1'b0;
        d0 = 8'hA0; d1 = 8'hB1; d2 = 8'hC2; d3 = 8'hD3;
        @(posedge clk);
        #1;

        // Reset held with all requests pending
        cyc(1, 4'hF, 4'hF, 1, 0, 4'h0, 2'd0, 0, 8'hA0);
        cyc(1, 4'hF, 4'hF, 1, 0, 4'h0, 2'd0, 0, 8'hA0);
        cyc(0, 4'hF, 4'hF, 1, 0, 4'h0, 2'd0, 0, 8'hA0);

        // Rotation 0,1,2,3,0 with single-beat bursts
        cyc(0, 4'hF, 4'hF, 1, 1, 4'h1, 2'd0, 1, 8'hA0);
        cyc(0, 4'hF, 4'hF, 1, 0, 4'h0, 2'd0, 0, 8'hA0);
        cyc(0, 4'hF, 4'hF, 1, 1, 4'h2, 2'd1, 1, 8'hB1);
        cyc(0, 4'hF, 4'hF, 1, 0, 4'h0, 2'd1, 0, 8'hB1);
        cyc(0, 4'hF, 4'hF, 1, 1, 4'h4, 2'd2, 1, 8'hC2);
        cyc(0, 4'hF, 4'hF, 1, 0, 4'h0, 2'd2, 0, 8'hC2);
        cyc(0, 4'hF, 4'hF, 1, 1, 4'h8, 2'd3, 1, 8'hD3);
        cyc(0, 4'hF, 4'hF, 1, 0, 4'h0, 2'd3, 0, 8'hD3);
        cyc(0, 4'hF, 4'hF, 1, 1, 4'h1, 2'd0, 1, 8'hA0);

        // Backpressure on requester 2 (ptr=1 now)
        cyc(0, 4'h4, 4'h4, 1, 0, 4'h0, 2'd0, 0, 8'hA0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 4'h4, 4'h4, 0, 1, 4'h0, 2'd2, 1, 8'hC2);
        end
        cyc(0, 4'h4, 4'h4, 1, 1, 4'h4, 2'd2, 1, 8'hC2);

        // Wrap: ptr=3, requesters 3 and 0
        cyc(0, 4'h9, 4'h9, 1, 0, 4'h0, 2'd2, 0, 8'hC2);
        cyc(0, 4'h9, 4'h9, 1, 1, 4'h8, 2'd3, 1, 8'hD3);
        cyc(0, 4'h9, 4'h9, 1, 0, 4'h0, 2'd3, 0, 8'hD3);
        cyc(0, 4'h9, 4'h9, 1, 1, 4'h1, 2'd0, 1, 8'hA0);
        // ptr=1: with everyone requesting, requester 1 wins
        cyc(0, 4'hF, 4'hF, 1, 0, 4'h0, 2'd0, 0, 8'hA0);
        cyc(0, 4'hF, 4'hF, 1, 1, 4'h2, 2'd1, 1, 8'hB1);

        // Burst lock: requester 0 sends three beats; last[1] is ignored
        cyc(0, 4'h3, 4'h0, 1, 0, 4'h0, 2'd1, 0, 8'hB1);
        d0 = 8'h10;
        cyc(0, 4'h3, 4'h2, 1, 1, 4'h1, 2'd0, 1, 8'h10);
        d0 = 8'h11;
        cyc(0, 4'h3, 4'h2, 1, 1, 4'h1, 2'd0, 1, 8'h11);
        d0 = 8'h12;
        cyc(0, 4'h3, 4'h1, 1, 1, 4'h1, 2'd0, 1, 8'h12);
        cyc(0, 4'h3, 4'h0, 1, 0, 4'h0, 2'd0, 0, 8'h12);
        cyc(0, 4'h3, 4'h2, 1, 1, 4'h2, 2'd1, 1, 8'hB1);

        // Reset during beat 2 of a burst from requester 1
        cyc(0, 4'h2, 4'h0, 1, 0, 4'h0, 2'd1, 0, 8'hB1);
        cyc(0, 4'h2, 4'h0, 1, 1, 4'h2, 2'd1, 1, 8'hB1);
        cyc(1, 4'h2, 4'h0, 1, 0, 4'h0, 2'd1, 1, 8'hB1);
        // ptr back to 0: requester 0 wins over 1..3
        cyc(0, 4'hF, 4'hF, 1, 0, 4'h0, 2'd0, 0, 8'h12);
        cyc(0, 4'hF, 4'hF, 1, 1, 4'h1, 2'd0, 1, 8'h12);

        // Requester drops req mid-burst: grant held, output stalls
        cyc(0, 4'h4, 4'h0, 1, 0, 4'h0, 2'd0, 0, 8'h12);
        cyc(0, 4'h0, 4'h0, 1, 0, 4'h0, 2'd2, 1, 8'hC2);
        cyc(0, 4'h4, 4'h0, 1, 1, 4'h4, 2'd2, 1, 8'hC2);
        cyc(0, 4'h4, 4'h4, 1, 1, 4'h4, 2'd2, 1, 8'hC2);
        cyc(0, 4'h0, 4'h0, 1, 0, 4'h0, 2'd2, 0, 8'hC2);

        @(posedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end

endmodule
